// File: rtl/cache_pkg.sv
// Shared definitions for the cache refill controller and the tag/data tables.
// Holds the default geometry, the byte-address field positions and the
// refill FSM state encoding.
package cache_pkg;

    // Default cache geometry: 24-bit tag, 8 lines, 8 words of 32 bits per block.
    localparam int TAG_W = 24;
    localparam int IDX_W = 3;
    localparam int WORDS = 8;

    // Byte-address field positions for the default geometry:
    // {tag[31:8], line[7:5], word[4:2], byte[1:0]}.
    localparam int ADDR_BYTE_LSB = 0;
    localparam int ADDR_WORD_LSB = 2;
    localparam int ADDR_WORD_MSB = 4;
    localparam int ADDR_LINE_LSB = 5;
    localparam int ADDR_LINE_MSB = 7;
    localparam int ADDR_TAG_LSB  = 8;
    localparam int ADDR_TAG_MSB  = 31;

    // Refill FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/cache_lru.sv
// Per-line LRU bit array for the two-way cache.
// Each bit names the way to be replaced next on that line. Read is
// combinational by line; one line can be updated per cycle.
module cache_lru #(
    parameter int IDX_W = cache_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_line,
    output logic             rd_victim,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_line,
    input  logic             upd_victim
);
    import cache_pkg::*;

    localparam int LINES = 1 << IDX_W;

    logic [LINES-1:0] lru_q;

    assign rd_victim = lru_q[rd_line];

    // LRU bits: cleared on reset, one line rewritten per update.
    always_ff @(posedge clk) begin
        if (rst) begin
            lru_q <= '0;
        end else if (upd_en) begin
            lru_q[upd_line] <= upd_victim;
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Two-way cache miss/refill controller.
// On a miss it latches the address and victim way, streams WORDS beats from
// memory into the data table, then writes the tag in a single COMMIT cycle.
// Build option: define CACHE_LRU_EN for a per-line LRU victim choice (via
// cache_lru); otherwise a single global round-robin bit picks the victim.
//
// Handshake: mem_req is held high for the whole FILL state; each cycle with
// mem_ready high delivers one beat on mem_rdata for the word on mem_addr,
// and mem_addr advances on the following cycle. mem_ready is ignored
// outside FILL.
module cache_refill_ctrl #(
    parameter int TAG_W = cache_pkg::TAG_W,
    parameter int IDX_W = cache_pkg::IDX_W,
    parameter int WORDS = cache_pkg::WORDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic [31:0]      cpu_addr,
    input  logic             hit,
    input  logic             channel,
    output logic             stall,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    output logic             tag_write,
    output logic             tag_pos,
    output logic [IDX_W-1:0] tag_line,
    output logic [TAG_W-1:0] tag_value,
    output logic             data_write,
    output logic             data_pos,
    output logic [IDX_W-1:0] data_line,
    output logic [2:0]       data_word,
    output logic [31:0]      data_value,
    output logic [1:0]       dbg_state
);
    import cache_pkg::*;

    localparam int WORD_W   = $clog2(WORDS);
    localparam int LINE_LSB = ADDR_WORD_LSB + WORD_W;
    localparam int TAG_LSB  = LINE_LSB + IDX_W;

    state_t            state_q;
    state_t            state_d;
    state_t            state_out;
    logic [WORD_W-1:0] word_cnt_q;
    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  line_q;
    logic              victim_q;

    logic [TAG_W-1:0]  cpu_tag;
    logic [IDX_W-1:0]  cpu_line;
    logic              miss;
    logic              last_beat;
    logic              victim_rd;

    assign cpu_tag   = cpu_addr[TAG_LSB +: TAG_W];
    assign cpu_line  = cpu_addr[LINE_LSB +: IDX_W];
    assign miss      = cpu_req & ~hit;
    assign last_beat = mem_ready && (word_cnt_q == WORD_W'(WORDS - 1));
    assign dbg_state = state_q;

`ifdef CACHE_LRU_EN
    logic             repl_upd;
    logic [IDX_W-1:0] repl_line;
    logic             repl_victim;
    logic             unused_addr_bits;

    // Replacement update: a hit makes the other way next victim; a commit
    // makes the way just filled most recent.
    always_comb begin
        repl_upd    = 1'b0;
        repl_line   = cpu_line;
        repl_victim = ~channel;
        if (state_q == IDLE && cpu_req && hit) begin
            repl_upd = 1'b1;
        end else if (state_q == COMMIT) begin
            repl_upd    = 1'b1;
            repl_line   = line_q;
            repl_victim = ~victim_q;
        end
    end

    cache_lru #(
        .IDX_W(IDX_W)
    ) u_lru (
        .clk        (clk),
        .rst        (rst),
        .rd_line    (cpu_line),
        .rd_victim  (victim_rd),
        .upd_en     (repl_upd),
        .upd_line   (repl_line),
        .upd_victim (repl_victim)
    );

    assign unused_addr_bits = ^cpu_addr[LINE_LSB-1:0];
`else
    logic rr_q;
    logic unused_addr_bits;

    // Global round-robin victim: flips once per committed refill only.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else if (state_q == COMMIT) begin
            rr_q <= ~rr_q;
        end
    end

    assign victim_rd        = rr_q;
    assign unused_addr_bits = ^{cpu_addr[LINE_LSB-1:0], channel};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: miss starts a refill, the last beat commits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (miss) state_d = FILL;
            FILL:    if (last_beat) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Refill context: latched on the missing access, beat counter in FILL.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q <= '0;
            tag_q      <= '0;
            line_q     <= '0;
            victim_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        tag_q      <= cpu_tag;
                        line_q     <= cpu_line;
                        victim_q   <= victim_rd;
                        word_cnt_q <= '0;
                    end
                end
                FILL: begin
                    // After the last beat the FSM leaves FILL, so no extra beat.
                    if (mem_ready) word_cnt_q <= word_cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs: driven from the registered state; reset forces IDLE behaviour
    // so nothing leaks from an abandoned refill during the reset cycle.
    always_comb begin
        state_out  = rst ? IDLE : state_q;
        stall      = miss;
        mem_req    = 1'b0;
        mem_addr   = '0;
        tag_write  = 1'b0;
        tag_pos    = 1'b0;
        tag_line   = '0;
        tag_value  = '0;
        data_write = 1'b0;
        data_pos   = 1'b0;
        data_line  = '0;
        data_word  = '0;
        data_value = '0;
        case (state_out)
            FILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {tag_q, line_q, word_cnt_q, 2'b00};
                if (mem_ready) begin
                    data_write = 1'b1;
                    data_value = mem_rdata;
                    data_word  = 3'(word_cnt_q);
                    data_line  = line_q;
                    data_pos   = victim_q;
                end
            end
            COMMIT: begin
                stall     = 1'b1;
                tag_write = 1'b1;
                tag_pos   = victim_q;
                tag_line  = line_q;
                tag_value = tag_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: directed scenarios plus random hit/miss traffic
// checked against a tag-table and replacement model. Follows CACHE_LRU_EN.
module tb_cache_refill_ctrl;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        hit = 1'b0;
  logic        channel = 1'b0;
  logic        stall, mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        tag_write, tag_pos;
  logic [2:0]  tag_line;
  logic [23:0] tag_value;
  logic        data_write, data_pos;
  logic [2:0]  data_line;
  logic [2:0]  data_word;
  logic [31:0] data_value;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  // Reference model: external tag table, per-line last-used way, commit count.
  logic [23:0] mdl_tag [0:1][0:7];
  bit          mdl_val [0:1][0:7];
  bit          last_used [0:7];
  int          commit_cnt;
  logic        last_tag_pos;
  logic [31:0] exp_q [$];

  cache_refill_ctrl dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .hit(hit),
    .channel(channel), .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .tag_write(tag_write),
    .tag_pos(tag_pos), .tag_line(tag_line), .tag_value(tag_value),
    .data_write(data_write), .data_pos(data_pos), .data_line(data_line),
    .data_word(data_word), .data_value(data_value), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic bit model_victim(input int line);
`ifdef CACHE_LRU_EN
    return ~last_used[line];
`else
    return commit_cnt[0];
`endif
  endfunction

  task automatic model_reset();
    commit_cnt = 0;
    for (int i = 0; i < 8; i++) last_used[i] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_req = 1'b0;
    hit = 1'b0;
    mem_ready = 1'b0;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // One full miss/refill/commit/re-lookup sequence with inline checks.
  // mode 0: mem_ready every cycle, 1: pattern 1,0,0, 2: random gaps.
  task automatic run_refill(input logic [23:0] tag, input logic [2:0] line,
                            input int mode, input bit disturb);
    logic [31:0] addr;
    logic [31:0] exp_addr;
    logic [2:0]  kw;
    logic        vic;
    logic        rdy;
    logic [31:0] d;
    int          k;
    int          cyc;
    addr = {tag, line, 3'($urandom), 2'($urandom)};
    vic = model_victim(line);
    k = 0;
    cyc = 0;
    exp_q.delete();
    cpu_req = 1'b1; cpu_addr = addr; hit = 1'b0; channel = 1'($urandom);
    mem_ready = 1'($urandom);
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL miss_stall got=%b exp=1", stall); end
    checks++; if (mem_req !== 1'b0 || data_write !== 1'b0) begin errors++; $display("FAIL idle_quiet mem_req=%b data_write=%b exp=0", mem_req, data_write); end
    tick();
    while (k < 8 && cyc < 200) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 3 == 0);
        default: rdy = (cyc % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      d = $urandom;
      mem_ready = rdy;
      mem_rdata = d;
      if (disturb && k == 3) begin
        cpu_req = 1'($urandom); cpu_addr = $urandom; hit = 1'($urandom); channel = 1'($urandom);
      end
      kw = k[2:0];
      exp_addr = {tag, line, kw, 2'b00};
      @(negedge clk);
      checks++; if (stall !== 1'b1 || mem_req !== 1'b1) begin errors++; $display("FAIL fill_req stall=%b mem_req=%b exp=1/1", stall, mem_req); end
      checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL fill_addr got=%h exp=%h", mem_addr, exp_addr); end
      checks++; if (data_write !== rdy || tag_write !== 1'b0) begin errors++; $display("FAIL fill_strobe data_write=%b exp=%b tag_write=%b", data_write, rdy, tag_write); end
      if (rdy) begin
        exp_q.push_back(d);
        checks++; if (data_word !== kw || data_line !== line || data_pos !== vic) begin errors++; $display("FAIL beat_pos word=%0d/%0d line=%0d/%0d pos=%b/%b", data_word, kw, data_line, line, data_pos, vic); end
        checks++; if (data_value !== exp_q.pop_front()) begin errors++; $display("FAIL beat_data got=%h exp=%h", data_value, d); end
        k++;
      end
      cyc++;
      tick();
    end
    checks++; if (k !== 8) begin errors++; $display("FAIL fill_timeout beats=%0d exp=8", k); end
    // COMMIT: mem_ready here is a stray beat and must be ignored
    mem_ready = 1'b1;
    mem_rdata = $urandom;
    @(negedge clk);
    checks++; if (tag_write !== 1'b1 || tag_pos !== vic || tag_line !== line || tag_value !== tag) begin errors++; $display("FAIL commit_tag we=%b pos=%b/%b line=%0d/%0d tag=%h/%h", tag_write, tag_pos, vic, tag_line, line, tag_value, tag); end
    checks++; if (data_write !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL commit_quiet data_write=%b mem_req=%b stall=%b exp=0/0/1", data_write, mem_req, stall); end
    last_tag_pos = tag_pos;
    mdl_tag[vic][line] = tag;
    mdl_val[vic][line] = 1'b1;
    commit_cnt++;
    last_used[line] = vic;
    tick();
    // Re-lookup of the original address now hits in the filled way
    mem_ready = 1'b0;
    cpu_req = 1'b1; cpu_addr = addr; hit = 1'b1; channel = vic;
    @(negedge clk);
    checks++; if (stall !== 1'b0 || tag_write !== 1'b0 || mem_req !== 1'b0 || dbg_state !== IDLE) begin errors++; $display("FAIL relookup stall=%b tag_write=%b mem_req=%b state=%0d exp=0/0/0/0", stall, tag_write, mem_req, dbg_state); end
    last_used[line] = vic;
    tick();
    cpu_req = 1'b0; hit = 1'b0;
  endtask

  task automatic do_hit(input logic [23:0] tag, input logic [2:0] line, input logic way);
    cpu_req = 1'b1; cpu_addr = {tag, line, 5'($urandom)}; hit = 1'b1; channel = way;
    mem_ready = 1'($urandom);
    @(negedge clk);
    checks++; if (stall !== 1'b0 || mem_req !== 1'b0 || tag_write !== 1'b0 || data_write !== 1'b0) begin errors++; $display("FAIL hit_quiet stall=%b mem_req=%b tw=%b dw=%b exp=0", stall, mem_req, tag_write, data_write); end
    last_used[line] = way;
    tick();
    cpu_req = 1'b0; hit = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_req = 1'b1; hit = 1'b0; cpu_addr = 32'hdead_beef; mem_ready = 1'b1;
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_stall_miss got=%b exp=1", stall); end
    checks++; if (mem_req !== 1'b0 || tag_write !== 1'b0 || data_write !== 1'b0 || mem_addr !== 32'd0 || data_value !== 32'd0 || tag_value !== 24'd0) begin errors++; $display("FAIL rst_outputs mem_req=%b tw=%b dw=%b addr=%h exp=0", mem_req, tag_write, data_write, mem_addr); end
    hit = 1'b1;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall_hit got=%b exp=0", stall); end
    @(posedge clk); #1;
    rst = 1'b0; cpu_req = 1'b0; hit = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if (dbg_state !== IDLE || mem_req !== 1'b0 || stall !== 1'b0 || mem_addr !== 32'd0) begin errors++; $display("FAIL post_rst state=%0d mem_req=%b stall=%b addr=%h exp=idle/0/0/0", dbg_state, mem_req, stall, mem_addr); end
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic test_basic_miss();
    run_refill(24'h000012, 3'd2, 0, 1'b0);
    checks++; if (last_tag_pos !== 1'b0) begin errors++; $display("FAIL basic_pos got=%b exp=0", last_tag_pos); end
  endtask

  task automatic test_victim_toggle();
    run_refill(24'h000034, 3'd2, 0, 1'b0);
    checks++; if (last_tag_pos !== 1'b1) begin errors++; $display("FAIL toggle_pos2 got=%b exp=1", last_tag_pos); end
    run_refill(24'h000056, 3'd2, 2, 1'b0);
    checks++; if (last_tag_pos !== 1'b0) begin errors++; $display("FAIL toggle_pos3 got=%b exp=0", last_tag_pos); end
  endtask

  task automatic test_replacement();
    logic exp_pos;
    do_reset();
    run_refill(24'h0000a1, 3'd5, 0, 1'b0);
    run_refill(24'h0000a2, 3'd5, 0, 1'b0);
    do_hit(24'h0000a1, 3'd5, 1'b0);
    run_refill(24'h0000a3, 3'd5, 0, 1'b0);
`ifdef CACHE_LRU_EN
    exp_pos = 1'b1;
`else
    exp_pos = 1'b0;
`endif
    checks++; if (last_tag_pos !== exp_pos) begin errors++; $display("FAIL repl_pos got=%b exp=%b", last_tag_pos, exp_pos); end
  endtask

  task automatic test_gapped();
    run_refill(24'h00c0de, 3'd3, 1, 1'b0);
  endtask

  task automatic test_reset_mid_fill();
    cpu_req = 1'b1; cpu_addr = {24'h0000f0, 3'd4, 5'd0}; hit = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1; mem_rdata = $urandom;
      tick();
    end
    rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || data_write !== 1'b0 || tag_write !== 1'b0 || mem_addr !== 32'd0 || stall !== 1'b1) begin errors++; $display("FAIL midrst_outputs mem_req=%b dw=%b tw=%b addr=%h stall=%b", mem_req, data_write, tag_write, mem_addr, stall); end
    tick();
    rst = 1'b0; cpu_req = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if (dbg_state !== IDLE || data_write !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL midrst_idle state=%0d dw=%b mem_req=%b exp=idle/0/0", dbg_state, data_write, mem_req); end
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_ready = 1'($urandom);
      @(negedge clk);
      checks++; if (tag_write !== 1'b0 || data_write !== 1'b0) begin errors++; $display("FAIL midrst_no_commit tw=%b dw=%b exp=0", tag_write, data_write); end
    end
    tick();
    mem_ready = 1'b0;
    run_refill(24'h0000f1, 3'd4, 2, 1'b0);
  endtask

  task automatic test_addr_change();
    run_refill(24'h00beef, 3'd6, 2, 1'b1);
  endtask

  task automatic test_random();
    logic [23:0] tag;
    logic [2:0]  line;
    for (int n = 0; n < 30; n++) begin
      line = 3'($urandom_range(0, 7));
      tag = 24'h000100 + 24'($urandom_range(0, 3));
      if (mdl_val[0][line] && mdl_tag[0][line] == tag) do_hit(tag, line, 1'b0);
      else if (mdl_val[1][line] && mdl_tag[1][line] == tag) do_hit(tag, line, 1'b1);
      else run_refill(tag, line, 2, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    for (int w = 0; w < 2; w++)
      for (int l = 0; l < 8; l++) begin
        mdl_tag[w][l] = '0;
        mdl_val[w][l] = 1'b0;
      end
    model_reset();
    test_reset();
    test_basic_miss();
    test_victim_toggle();
    test_replacement();
    test_gapped();
    test_reset_mid_fill();
    test_addr_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have parameter TAG_W, default 24, tag width.
REQ-002 SHALL have parameter IDX_W, default 3, line index width (8 lines).
REQ-003 SHALL have parameter WORDS, default 8, 32-bit words per block.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  reset.
REQ-005 Clocking is fixed: one clock, clk; reset rst is synchronous and active-high.
REQ-006 cpu_req  in  1  CPU access valid; cpu_addr  in  32  byte address {tag[31:8], line[7:5], word[4:2], byte[1:0]}.
REQ-007 hit  in  1  and channel  in  1  are the tag-table lookup results for cpu_addr; channel=1 means way 1.
REQ-008 stall  out  1  CPU must hold its request.
REQ-009 mem_req  out  1  refill beat request; mem_addr  out  32  word address; mem_ready  in  1  beat valid; mem_rdata  in  32  beat data.
REQ-010 tag_write  out  1, tag_pos  out  1, tag_line  out  IDX_W, tag_value  out  TAG_W: tag-table write port.
REQ-011 data_write  out  1, data_pos  out  1, data_line  out  IDX_W, data_word  out  3, data_value  out  32: data-table write port.

Function
REQ-012 SHALL implement the FSM states IDLE, FILL and COMMIT.
REQ-013 IDLE: stall = cpu_req & ~hit, combinationally; on cpu_req & ~hit, latch tag, line and the victim way; clear word_cnt; go to FILL.
REQ-014 IDLE, cpu_req & hit: update the replacement state for that line using channel; no other action.
REQ-015 FILL: stall=1; mem_req=1; mem_addr = {latched tag, line, word_cnt, 2'b00}.
REQ-016 FILL, mem_ready=1: data_write=1 that cycle; data_value=mem_rdata; data_word=word_cnt; data_line=line; data_pos=victim; word_cnt increments.
REQ-017 FILL, mem_ready with word_cnt==WORDS-1: go to COMMIT. word_cnt SHALL NOT wrap into a ninth beat.
REQ-018 COMMIT: stall=1; tag_write=1 for exactly one cycle with tag_pos=victim, tag_line=line, tag_value=latched tag; set the replacement state so the other way is next victim; go to IDLE.
REQ-019 Miss latency: WORDS mem_ready beats + 1 COMMIT cycle. The first IDLE cycle after COMMIT re-looks-up and sees hit.
REQ-020 cpu_req deasserting or cpu_addr changing during FILL/COMMIT SHALL NOT abort the refill; the latched values are used.
REQ-021 mem_ready outside FILL SHALL be ignored.
REQ-022 All write strobes (tag_write, data_write) and mem_req SHALL be 0 when not specified above.

Reset
REQ-023 On rst, the following SHALL be cleared on the next edge, including mid-refill: state to IDLE, word_cnt=0, latched tag/line/victim=0, all replacement bits=0.
REQ-024 During reset and the cycle after, outputs SHALL read: stall=cpu_req&~hit, mem_req=0, tag_write=0, data_write=0, all address/data outputs 0.
REQ-025 A partially filled block abandoned by reset SHALL never be marked valid, because COMMIT was not reached.

Configuration
REQ-026 Macro CACHE_LRU_EN defined: one LRU bit per line (victim = LRU bit); updated on hit (REQ-014) and on COMMIT.
REQ-027 Macro CACHE_LRU_EN undefined: a single global round-robin bit is the victim; it toggles only on COMMIT; hits do not change it.

Structure
REQ-028 Package cache_pkg SHALL hold TAG_W, IDX_W, WORDS, the address field slice positions, and the FSM state enum; it is shared with the tag and data tables.
REQ-029 Sub-module cache_lru (per-line LRU bit array: read by line, update on hit/commit, sync reset) SHALL be instantiated only under CACHE_LRU_EN.

Verification
REQ-030 Reset, then cpu_req=1, addr=0x0000_1240, hit=0 -> stall=1; FILL mem_addr 0x1240, 0x1244 ... 0x125C; 8 data_write with line=2, pos=0; tag_write with tag=0x000012, line=2, pos=0.
REQ-031 Second miss, same line 2, tag 0x000034 -> pos=1 (victim toggled); third miss, tag 0x000056 -> pos=0.
REQ-032 With CACHE_LRU_EN: fill both ways of line 5, hit way 0 (channel=0), then miss -> pos=1. Without CACHE_LRU_EN the same sequence -> pos=0.
REQ-033 mem_ready gapped (1,0,0,1,...) -> exactly 8 data_write, data_word 0..7 in order, no extra beat, tag_write one cycle after 8th beat.
REQ-034 rst asserted after 3 beats -> next cycle state IDLE, no tag_write ever issued; a subsequent miss restarts at word 0.
REQ-035 cpu_req dropped and cpu_addr changed mid-FILL -> refill completes with the originally latched address.
